// File: rtl/multicore_launch_arb.sv
// Staggered reset launcher for an array of identical cores, plus a round-robin
// collector that funnels their results into one registered valid/ready stream.
module multicore_launch_arb #(
   parameter int N_CORES   = 37,
   parameter int DW        = 28,
   parameter int TW        = 4,
   parameter int STAGGER   = 9,
   parameter int TAG_MATCH = 0,
   parameter int CIDW      = $clog2(N_CORES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt,
   output logic [N_CORES-1:0]    core_rst,
   input  logic [N_CORES*DW-1:0] core_dout,
   input  logic [N_CORES*TW-1:0] core_tag,
   output logic [N_CORES-1:0]    core_ack,
   output logic [DW-1:0]         out_data,
   output logic [TW-1:0]         out_tag,
   output logic [CIDW-1:0]       out_core,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  launch_done
);

   localparam int CNTW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [CIDW-1:0]    idx_q, idx_d;
   logic [N_CORES-1:0] coreRst_q, coreRst_d;
   logic               launchDone_q, launchDone_d;

   logic [N_CORES-1:0] req;
   logic [CIDW-1:0]    grantIdx;
   logic               found;
   logic               load;
   logic               grantEn;

   logic [DW-1:0]      outData_q;
   logic [TW-1:0]      outTag_q;
   logic [CIDW-1:0]    outCore_q;
   logic               outValid_q;
   logic [N_CORES-1:0] coreAck_q;
   logic [CIDW-1:0]    last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         coreRst_q    <= '1;
         launchDone_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         coreRst_q    <= coreRst_d;
         launchDone_q <= launchDone_d;
      end
   end

   // Launcher: core 0 leaves reset with the start edge, each later core STAGGER clocks after the previous one
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      coreRst_d    = coreRst_q;
      launchDone_d = launchDone_q;
      if (halt) begin
         state_d      = IDLE;
         cnt_d        = '0;
         idx_d        = '0;
         coreRst_d    = '1;
         launchDone_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d      = LAUNCH;
                  coreRst_d[0] = 1'b0;
                  cnt_d        = '0;
                  idx_d        = CIDW'(1);
               end
            end
            LAUNCH: begin
               if (cnt_q == CNTW'(STAGGER - 1)) begin
                  coreRst_d[idx_q] = 1'b0;
                  cnt_d            = '0;
                  if (idx_q == CIDW'(N_CORES - 1)) begin
                     state_d      = RUN;
                     launchDone_d = 1'b1;
                  end else begin
                     idx_d = idx_q + CIDW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            RUN: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      req = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (TAG_MATCH == 0) req[i] = !coreRst_q[i] && (core_tag[i*TW +: TW] != '0);
         else                req[i] = !coreRst_q[i] && (core_tag[i*TW +: TW] == TW'(TAG_MATCH));
      end
   end

   // Round-robin: scan starting just after the last granted core, wrapping around
   always_comb begin
      int j;
      j        = 0;
      found    = 1'b0;
      grantIdx = '0;
      for (int k = 1; k <= N_CORES; k++) begin
         j = int'(last_q) + k;
         if (j >= N_CORES) j = j - N_CORES;
         if (!found && req[j]) begin
            found    = 1'b1;
            grantIdx = CIDW'(j);
         end
      end
   end

   assign load    = !outValid_q || out_ready;
   assign grantEn = load && found && !halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outData_q  <= '0;
         outTag_q   <= '0;
         outCore_q  <= '0;
         outValid_q <= 1'b0;
         coreAck_q  <= '0;
         last_q     <= CIDW'(N_CORES - 1);
      end else begin
         coreAck_q <= '0;
         if (grantEn) begin
            outData_q           <= core_dout[int'(grantIdx)*DW +: DW];
            outTag_q            <= core_tag[int'(grantIdx)*TW +: TW];
            outCore_q           <= grantIdx;
            outValid_q          <= 1'b1;
            coreAck_q[grantIdx] <= 1'b1;
            last_q              <= grantIdx;
         end else if (load) begin
            outValid_q <= 1'b0;
         end
      end
   end

   assign core_rst    = coreRst_q;
   assign core_ack    = coreAck_q;
   assign out_data    = outData_q;
   assign out_tag     = outTag_q;
   assign out_core    = outCore_q;
   assign out_valid   = outValid_q;
   assign launch_done = launchDone_q;

endmodule

// File: tb/tb_multicore_launch_arb.sv
// Bench for multicore_launch_arb: two 4-core instances (tag-any and tag==1) with
// a result scoreboard per instance and direct checks of the launcher sequence.
module tb_multicore_launch_arb;

   localparam int N       = 4;
   localparam int DW      = 28;
   localparam int TW      = 4;
   localparam int STAGGER = 3;
   localparam int CIDW    = 2;

   typedef struct {
      logic [DW-1:0]   data;
      logic [TW-1:0]   tag;
      logic [CIDW-1:0] core;
   } word_t;

   logic clk = 1'b0;
   logic rst, startI, haltI, readyI, ready1;
   logic [DW-1:0] dataArr [N];
   logic [TW-1:0] tag0Arr [N];
   logic [TW-1:0] tag1Arr [N];
   logic [N*DW-1:0] coreDout;
   logic [N*TW-1:0] coreTag0, coreTag1;

   logic [N-1:0]    coreRst0, coreAck0, coreRst1, coreAck1;
   logic [DW-1:0]   outData0, outData1;
   logic [TW-1:0]   outTag0, outTag1;
   logic [CIDW-1:0] outCore0, outCore1;
   logic            outValid0, outValid1, launchDone0, launchDone1;

   word_t q0[$];
   word_t q1[$];
   int    vectors     = 0;
   int    miscompares = 0;
   logic  prevLoad0   = 1'b1;

   always #5 clk = ~clk;

   // Flatten the per-core stimulus arrays onto the packed core buses
   always_comb begin
      for (int i = 0; i < N; i++) begin
         coreDout[i*DW +: DW] = dataArr[i];
         coreTag0[i*TW +: TW] = tag0Arr[i];
         coreTag1[i*TW +: TW] = tag1Arr[i];
      end
   end

   multicore_launch_arb #(.N_CORES(N), .DW(DW), .TW(TW), .STAGGER(STAGGER), .TAG_MATCH(0)) dut0 (
      .clk(clk), .rst(rst), .start(startI), .halt(haltI),
      .core_rst(coreRst0), .core_dout(coreDout), .core_tag(coreTag0), .core_ack(coreAck0),
      .out_data(outData0), .out_tag(outTag0), .out_core(outCore0), .out_valid(outValid0),
      .out_ready(readyI), .launch_done(launchDone0)
   );

   multicore_launch_arb #(.N_CORES(N), .DW(DW), .TW(TW), .STAGGER(STAGGER), .TAG_MATCH(1)) dut1 (
      .clk(clk), .rst(rst), .start(startI), .halt(haltI),
      .core_rst(coreRst1), .core_dout(coreDout), .core_tag(coreTag1), .core_ack(coreAck1),
      .out_data(outData1), .out_tag(outTag1), .out_core(outCore1), .out_valid(outValid1),
      .out_ready(ready1), .launch_done(launchDone1)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic s, input logic h);
      startI = s;
      haltI  = h;
      tick();
      startI = 1'b0;
      haltI  = 1'b0;
   endtask

   task automatic pushWord0(input int c);
      word_t w;
      w.data = dataArr[c];
      w.tag  = tag0Arr[c];
      w.core = CIDW'(c);
      q0.push_back(w);
   endtask

   task automatic pushWord1(input int c);
      word_t w;
      w.data = dataArr[c];
      w.tag  = tag1Arr[c];
      w.core = CIDW'(c);
      q1.push_back(w);
   endtask

   // Pulse start, then follow the release pattern for n cycles after the start edge
   task automatic checkLaunch(input int n);
      int       rel;
      logic [N-1:0] expRst;
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < n; k++) begin
         rel = k / STAGGER + 1;
         if (rel > N) rel = N;
         expRst = 4'hF << rel;
         checkOutput("coreRst0", coreRst0, expRst);
         checkOutput("coreRst1", coreRst1, expRst);
         checkOutput("launchDone0", launchDone0, (rel == N) ? 1 : 0);
         tick();
      end
   endtask

   // Scoreboard for the tag-any instance: a new word must match the queue head and carry its ack
   always @(negedge clk) begin
      logic [N-1:0] expAck;
      if (rst) begin
         prevLoad0 <= 1'b1;
      end else begin
         expAck = '0;
         if (outValid0) begin
            if (q0.size() == 0) begin
               checkOutput("q0Depth", 32'(q0.size()), 1);
            end else begin
               if (prevLoad0) expAck = 4'b0001 << q0[0].core;
               checkOutput("outData0", outData0, q0[0].data);
               checkOutput("outTag0", outTag0, q0[0].tag);
               checkOutput("outCore0", outCore0, q0[0].core);
               if (readyI) void'(q0.pop_front());
            end
         end
         checkOutput("coreAck0", coreAck0, expAck);
         prevLoad0 <= !outValid0 || readyI;
      end
   end

   // Scoreboard for the tag-match instance, whose sink is always ready
   always @(negedge clk) begin
      logic [N-1:0] expAck;
      if (!rst) begin
         expAck = '0;
         if (outValid1) begin
            if (q1.size() == 0) begin
               checkOutput("q1Depth", 32'(q1.size()), 1);
            end else begin
               expAck = 4'b0001 << q1[0].core;
               checkOutput("outData1", outData1, q1[0].data);
               checkOutput("outCore1", outCore1, q1[0].core);
               void'(q1.pop_front());
            end
         end
         checkOutput("coreAck1", coreAck1, expAck);
      end
   end

   initial begin
      rst    = 1'b1;
      startI = 1'b0;
      haltI  = 1'b0;
      readyI = 1'b1;
      ready1 = 1'b1;
      dataArr[0] = 28'h8000001;
      dataArr[1] = 28'h0123456;
      dataArr[2] = 28'h0000022;
      dataArr[3] = 28'hFFFFFF3;
      for (int i = 0; i < N; i++) begin
         tag0Arr[i] = '0;
         tag1Arr[i] = '0;
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("rstCoreRst", coreRst0, 4'hF);
      checkOutput("rstValid", outValid0, 0);
      checkOutput("rstAck", coreAck0, 0);
      checkOutput("rstDone", launchDone0, 0);
      checkOutput("rstData", outData0, 0);
      checkOutput("rstCore", outCore0, 0);
      checkOutput("rstTag", outTag0, 0);
      rst = 1'b0;
      tick();

      $display("[TB] staggered launch");
      checkLaunch(12);

      $display("[TB] round-robin over cores 0,2,3");
      tag0Arr[0] = 4'd1;
      tag0Arr[2] = 4'd1;
      tag0Arr[3] = 4'd1;
      pushWord0(0); tick();
      pushWord0(2); tick();
      pushWord0(3); tick();
      pushWord0(0); tick();
      pushWord0(2); tick();
      pushWord0(3); tick();
      tag0Arr[0] = '0;
      tag0Arr[2] = '0;
      tag0Arr[3] = '0;
      tick();

      $display("[TB] tag matching");
      tag0Arr[1] = 4'd2;
      tag0Arr[2] = 4'd1;
      tag1Arr[1] = 4'd2;
      tag1Arr[2] = 4'd1;
      pushWord0(1);
      pushWord1(2);
      tick();
      tag0Arr[1] = '0;
      tag1Arr[2] = '0;
      pushWord0(2);
      tick();
      tag0Arr[2] = '0;
      tag1Arr[1] = '0;
      tick();

      $display("[TB] backpressure");
      readyI     = 1'b0;
      tag0Arr[0] = 4'd1;
      tag0Arr[1] = 4'd1;
      pushWord0(0);
      tick();
      tag0Arr[0] = '0;
      repeat (5) tick();
      readyI = 1'b1;
      pushWord0(1);
      tick();
      tag0Arr[1] = '0;
      tick();
      tick();

      $display("[TB] halt mid-launch");
      applyStimulus(1'b0, 1'b1);
      checkOutput("haltRst", coreRst0, 4'hF);
      checkOutput("haltDone", launchDone0, 0);
      checkLaunch(4);
      applyStimulus(1'b0, 1'b1);
      checkOutput("halt2Rst", coreRst0, 4'hF);
      checkOutput("halt2Done", launchDone0, 0);
      tick();
      checkOutput("idleRst", coreRst0, 4'hF);
      checkLaunch(12);

      $display("[TB] async reset mid-launch");
      applyStimulus(1'b0, 1'b1);
      checkLaunch(1);
      readyI     = 1'b0;
      tag0Arr[0] = 4'd1;
      pushWord0(0);
      tick();
      tag0Arr[0] = '0;
      checkOutput("preRstValid", outValid0, 1);
      checkOutput("preRstAck", coreAck0, 4'b0001);
      #2 rst = 1'b1;
      #1;
      checkOutput("arstCoreRst", coreRst0, 4'hF);
      checkOutput("arstValid", outValid0, 0);
      checkOutput("arstAck", coreAck0, 0);
      checkOutput("arstDone", launchDone0, 0);
      checkOutput("arstData", outData0, 0);
      checkOutput("arstTag", outTag0, 0);
      checkOutput("arstCore", outCore0, 0);
      q0.delete();
      #3 rst = 1'b0;
      readyI = 1'b1;
      tick();
      checkOutput("postRstRst", coreRst0, 4'hF);
      tick();

      checkOutput("q0Empty", 32'(q0.size()), 0);
      checkOutput("q1Empty", 32'(q1.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
